// File: rtl/joy_db15_pkg.sv
// Shared constants, state type and frame builder for the DB15 joystick transmitter.
package joy_db15_pkg;

    localparam int unsigned FRAME_BITS_DEF = 24;
    localparam int unsigned P2_OFFSET      = 12;

    // Button positions within a player's 12-bit field
    typedef enum int unsigned {
        BTN_R  = 0,
        BTN_L  = 1,
        BTN_D  = 2,
        BTN_U  = 3,
        BTN_A  = 4,
        BTN_B  = 5,
        BTN_C  = 6,
        BTN_D_ = 7,
        BTN_E  = 8,
        BTN_F  = 9,
        BTN_S  = 10,
        BTN_LS = 11
    } btn_e;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

    // Player 1 occupies the low half, player 2 the high half; bits [15:12] dropped
    function automatic logic [FRAME_BITS_DEF-1:0] build_frame(input logic [15:0] j1,
                                                              input logic [15:0] j2);
        build_frame = {j2[P2_OFFSET-1:0], j1[P2_OFFSET-1:0]};
    endfunction

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Two-flop synchronizer (idles high) with a registered-history edge detector.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level  = s2;
    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 splitter emulation: latches both players while JOY_LOAD is low and shifts
// the active-low frame out on JOY_DATA, one bit per JOY_CLK rising edge.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter  int unsigned FRAME_BITS  = FRAME_BITS_DEF,
    parameter  int unsigned TIMEOUT_CYC = 2_500_000,
    localparam int unsigned IDX_W       = $clog2(FRAME_BITS + 1),
    localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      joystick1,
    input  logic [15:0]      joystick2,
    input  logic             joy_clk,
    input  logic             joy_load,
    output logic             joy_data,
    output logic             frame_done,
    output logic             link_active,
    output logic [IDX_W-1:0] bit_index
);

    logic load_lvl, load_fall, clk_rise;
    logic unused_load_rise, unused_clk_lvl, unused_clk_fall;

    sync_edge u_sync_load (
        .clk    (clk),
        .reset  (reset),
        .din    (joy_load),
        .level  (load_lvl),
        .rise_c (unused_load_rise),
        .fall_c (load_fall)
    );

    sync_edge u_sync_clk (
        .clk    (clk),
        .reset  (reset),
        .din    (joy_clk),
        .level  (unused_clk_lvl),
        .rise_c (clk_rise),
        .fall_c (unused_clk_fall)
    );

    logic [FRAME_BITS-1:0] frame_c;
    assign frame_c = FRAME_BITS'(build_frame(joystick1, joystick2));

    tx_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]      idx_d;
    logic                  done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SHIFT;
            shreg_q    <= '1;
            bit_index  <= IDX_W'(FRAME_BITS);
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_index  <= idx_d;
            frame_done <= done_d;
        end
    end

    // First SHIFT cycle only freezes the snapshot; a coincident clock edge is dropped
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = bit_index;
        done_d  = 1'b0;
        if (!load_lvl) begin
            state_d = ST_LOAD;
            shreg_d = ~frame_c;
            idx_d   = '0;
        end else if (state_q == ST_LOAD) begin
            state_d = ST_SHIFT;
        end else if (clk_rise) begin
            shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
            if (bit_index != IDX_W'(FRAME_BITS)) begin
                idx_d  = bit_index + IDX_W'(1);
                done_d = (bit_index == IDX_W'(FRAME_BITS - 1));
            end
        end
    end

    assign joy_data = shreg_q[0];

    logic [WD_W-1:0] wd_cnt;

    // Link watchdog: restarted by every load, saturates at the timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            link_active <= 1'b0;
        end else if (load_fall) begin
            wd_cnt      <= '0;
            link_active <= 1'b1;
        end else if (wd_cnt != WD_W'(TIMEOUT_CYC)) begin
            wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_cnt == WD_W'(TIMEOUT_CYC - 1))
                link_active <= 1'b0;
        end
    end

endmodule
